// File: rtl/fixed_pkg.sv
// Shared fixed-point types and saturation helpers for the divider datapath.
package fixed_pkg;
    localparam int FIXED_WIDTH      = 32;
    localparam int FIXED_FRAC_WIDTH = 14;
    localparam int SAT_MAX_W        = 64;

    typedef logic signed [FIXED_WIDTH-1:0] fixed_t;

    typedef struct packed {
        logic div_zero;
        logic overflow;
    } div_status_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_DONE
    } div_state_t;

    // Callers keep the low WIDTH bits of the returned value.
    function automatic logic [SAT_MAX_W-1:0] fixed_max(input int width);
        return (SAT_MAX_W'(1) << (width - 1)) - SAT_MAX_W'(1);
    endfunction

    function automatic logic [SAT_MAX_W-1:0] fixed_min(input int width);
        return SAT_MAX_W'(1) << (width - 1);
    endfunction
endpackage

// File: rtl/fixed_div_step.sv
// One restoring division step: shift in the next dividend bit, compare, subtract.
module fixed_div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_rem,
    input  logic [WIDTH-1:0] i_div,
    input  logic             i_bit,
    output logic [WIDTH-1:0] o_rem,
    output logic             o_q
);
    logic [WIDTH:0]   w_shift;
    logic [WIDTH-1:0] w_diff;

    assign w_shift = {i_rem, i_bit};
    assign o_q     = (w_shift >= {1'b0, i_div});
    // Result is below i_div whenever o_q is set, so WIDTH bits hold it exactly.
    assign w_diff  = w_shift[WIDTH-1:0] - i_div;
    assign o_rem   = o_q ? w_diff : w_shift[WIDTH-1:0];
endmodule

// File: rtl/fixed_div_iter.sv
// Iterative signed fixed-point divider q = (a << FRAC) / b with saturation and tag.
// States: IDLE = accept operands | CALC = BPC restoring steps per cycle | DONE = result held until out_ready
module fixed_div_iter
    import fixed_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int FRAC  = 14,
    parameter int BPC   = 2,
    parameter int TAG_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] q,
    output logic [TAG_W-1:0] out_tag,
    output logic             div_zero,
    output logic             overflow
);
    localparam int N     = WIDTH + FRAC;
    localparam int ITER  = N / BPC;
    localparam int CNT_W = $clog2(ITER + 1);
    localparam logic [SAT_MAX_W-1:0] MAX_FULL = fixed_max(WIDTH);
    localparam logic [SAT_MAX_W-1:0] MIN_FULL = fixed_min(WIDTH);
    localparam logic [WIDTH-1:0]     Q_MAX    = MAX_FULL[WIDTH-1:0];
    localparam logic [WIDTH-1:0]     Q_MIN    = MIN_FULL[WIDTH-1:0];

    if (!(BPC == 1 || BPC == 2 || BPC == 4) || ((N % BPC) != 0) || FRAC < 1) begin : g_bad_cfg
        $error("fixed_div_iter: unsupported WIDTH/FRAC/BPC combination");
    end

    div_state_t       r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [N-1:0]     r_dvd;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_div;
    logic             r_neg;
    logic [TAG_W-1:0] r_tag;
    logic [WIDTH-1:0] r_q;
    div_status_t      r_status;

    logic             w_accept;
    logic             w_b_zero;
    logic [WIDTH-1:0] w_abs_a;
    logic [WIDTH-1:0] w_abs_b;
    logic [WIDTH-1:0] w_rem [BPC+1];
    logic [BPC-1:0]   w_qbits;
    logic [N-1:0]     w_dvd_nxt;
    logic             w_ovf;
    logic [WIDTH-1:0] w_q_fin;

    assign in_ready  = ~reset & ((r_state == ST_IDLE) | ((r_state == ST_DONE) & out_ready));
    assign w_accept  = in_valid & in_ready;
    assign w_b_zero  = (b == '0);
    // Unsigned magnitude: the most-negative operand maps to 2^(WIDTH-1) without wrapping.
    assign w_abs_a   = a[WIDTH-1] ? -a : a;
    assign w_abs_b   = b[WIDTH-1] ? -b : b;

    assign w_rem[0] = r_rem;
    for (genvar k = 0; k < BPC; k++) begin : g_step
        fixed_div_step #(.WIDTH(WIDTH)) u_step (
            .i_rem (w_rem[k]),
            .i_div (r_div),
            .i_bit (r_dvd[N-1-k]),
            .o_rem (w_rem[k+1]),
            .o_q   (w_qbits[BPC-1-k])
        );
    end

    // Dividend bits leave at the top while quotient bits fill in from the bottom.
    assign w_dvd_nxt = {r_dvd[N-1-BPC:0], w_qbits};

    always_comb begin
        w_ovf   = 1'b0;
        w_q_fin = w_dvd_nxt[WIDTH-1:0];
        if (r_neg) begin
            w_ovf   = (|w_dvd_nxt[N-1:WIDTH]) | (w_dvd_nxt[WIDTH-1] & (|w_dvd_nxt[WIDTH-2:0]));
            w_q_fin = w_ovf ? Q_MIN : -w_dvd_nxt[WIDTH-1:0];
        end else begin
            w_ovf   = |w_dvd_nxt[N-1:WIDTH-1];
            w_q_fin = w_ovf ? Q_MAX : w_dvd_nxt[WIDTH-1:0];
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_state_nxt = w_b_zero ? ST_DONE : ST_CALC;
            ST_CALC: if (r_cnt == CNT_W'(1)) w_state_nxt = ST_DONE;
            ST_DONE: if (out_ready) w_state_nxt = w_accept ? (w_b_zero ? ST_DONE : ST_CALC) : ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt    <= '0;
            r_dvd    <= '0;
            r_rem    <= '0;
            r_div    <= '0;
            r_neg    <= 1'b0;
            r_tag    <= '0;
            r_q      <= '0;
            r_status <= '0;
        end else if (w_accept) begin
            r_dvd <= {w_abs_a, {FRAC{1'b0}}};
            r_rem <= '0;
            r_div <= w_abs_b;
            r_neg <= a[WIDTH-1] ^ b[WIDTH-1];
            r_tag <= in_tag;
            r_cnt <= CNT_W'(ITER);
            if (w_b_zero) begin
                r_q      <= a[WIDTH-1] ? Q_MIN : Q_MAX;
                r_status <= '{div_zero: 1'b1, overflow: 1'b0};
            end
        end else if (r_state == ST_CALC) begin
            r_dvd <= w_dvd_nxt;
            r_rem <= w_rem[BPC];
            r_cnt <= r_cnt - CNT_W'(1);
            if (r_cnt == CNT_W'(1)) begin
                r_q      <= w_q_fin;
                r_status <= '{div_zero: 1'b0, overflow: w_ovf};
            end
        end
    end

    assign out_valid = (r_state == ST_DONE);
    assign q         = r_q;
    assign out_tag   = r_tag;
    assign div_zero  = r_status.div_zero;
    assign overflow  = r_status.overflow;
endmodule

// File: tb/tb_fixed_div_iter.sv
// Directed checks of fixed_div_iter: latency, rounding, saturation, handshake and reset.
module tb_fixed_div_iter;
    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic [7:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] q;
    logic [7:0]  out_tag;
    logic        div_zero;
    logic        overflow;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    fixed_div_iter #(.WIDTH(32), .FRAC(14), .BPC(2), .TAG_W(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .q         (q),
        .out_tag   (out_tag),
        .div_zero  (div_zero),
        .overflow  (overflow)
    );

    function automatic logic [31:0] fx(input int v);
        return 32'(v * 16384);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present operands and return just after the accepting edge.
    task automatic send(input logic [31:0] va, input logic [31:0] vb, input logic [7:0] vt);
        a = va; b = vb; in_tag = vt; in_valid = 1'b1;
        for (int i = 0; i < 100 && !in_ready; i++) tick();
        tick();
        in_valid = 1'b0;
    endtask

    // Edges from the accept edge (counted as 1) until out_valid is seen.
    task automatic wait_valid(output int lat);
        lat = 1;
        while (!out_valid && lat < 200) begin
            tick();
            lat++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; in_tag = '0;
        repeat (3) tick();
        checks++;
        if (out_valid !== 1'b0 || q !== 32'h0 || out_tag !== 8'h0 || div_zero !== 1'b0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got valid=%b q=%h tag=%h dz=%b ovf=%b, want all 0", out_valid, q, out_tag, div_zero, overflow);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_basic();
        int lat;
        send(fx(2057), fx(7), 8'h5A);
        wait_valid(lat);
        checks++;
        if (lat != 24) begin errors++; $display("FAIL basic_latency: got %0d want 24", lat); end
        checks++;
        if (q !== 32'd4814555) begin errors++; $display("FAIL basic_q: got %0d want 4814555", $signed(q)); end
        checks++;
        if (out_tag !== 8'h5A || div_zero !== 1'b0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL basic_tag_flags: got tag=%h dz=%b ovf=%b want 5a 0 0", out_tag, div_zero, overflow);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_consumed: out_valid=%b want 0", out_valid); end
    endtask

    task automatic test_back_to_back();
        int lat;
        a = fx(157); b = fx(7); in_tag = 8'h11; in_valid = 1'b1;
        for (int i = 0; i < 100 && !in_ready; i++) tick();
        tick();
        a = fx(-157); in_tag = 8'h22;
        wait_valid(lat);
        checks++;
        if (lat != 24 || q !== 32'd367469 || out_tag !== 8'h11) begin
            errors++;
            $display("FAIL b2b_first: got lat=%0d q=%0d tag=%h want 24 367469 11", lat, $signed(q), out_tag);
        end
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_with_result: got %b want 1", in_ready); end
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_second_accepted: out_valid=%b want 0", out_valid); end
        wait_valid(lat);
        checks++;
        if (lat != 24 || q !== 32'hFFFA6493 || out_tag !== 8'h22) begin
            errors++;
            $display("FAIL b2b_second: got lat=%0d q=%0d tag=%h want 24 -367469 22", lat, $signed(q), out_tag);
        end
        tick();
    endtask

    task automatic test_div_zero();
        int lat;
        send(fx(5), 32'h0, 8'h03);
        wait_valid(lat);
        checks++;
        if (lat != 1 || q !== 32'h7FFFFFFF || div_zero !== 1'b1 || overflow !== 1'b0 || out_tag !== 8'h03) begin
            errors++;
            $display("FAIL dz_pos: got lat=%0d q=%h dz=%b ovf=%b tag=%h want 1 7fffffff 1 0 03", lat, q, div_zero, overflow, out_tag);
        end
        tick();
        send(fx(-5), 32'h0, 8'h04);
        wait_valid(lat);
        checks++;
        if (lat != 1 || q !== 32'h80000000 || div_zero !== 1'b1 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL dz_neg: got lat=%0d q=%h dz=%b ovf=%b want 1 80000000 1 0", lat, q, div_zero, overflow);
        end
        tick();
    endtask

    task automatic test_overflow();
        int lat;
        send(fx(100000), 32'h1, 8'h05);
        wait_valid(lat);
        checks++;
        if (q !== 32'h7FFFFFFF || overflow !== 1'b1 || div_zero !== 1'b0) begin
            errors++;
            $display("FAIL ovf_pos: got q=%h ovf=%b dz=%b want 7fffffff 1 0", q, overflow, div_zero);
        end
        tick();
        send(32'h80000000, fx(-1), 8'h06);
        wait_valid(lat);
        checks++;
        if (q !== 32'h7FFFFFFF || overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_minneg: got q=%h ovf=%b want 7fffffff 1", q, overflow);
        end
        tick();
        send(32'h80000000, fx(1), 8'h07);
        wait_valid(lat);
        checks++;
        if (q !== 32'h80000000 || overflow !== 1'b0 || div_zero !== 1'b0) begin
            errors++;
            $display("FAIL min_exact: got q=%h ovf=%b dz=%b want 80000000 0 0", q, overflow, div_zero);
        end
        tick();
        send(32'h0, fx(3), 8'h08);
        wait_valid(lat);
        checks++;
        if (q !== 32'h0 || overflow !== 1'b0 || div_zero !== 1'b0) begin
            errors++;
            $display("FAIL zero_dividend: got q=%h ovf=%b dz=%b want 0 0 0", q, overflow, div_zero);
        end
        tick();
        send(fx(-1), fx(3), 8'h09);
        wait_valid(lat);
        checks++;
        if (q !== 32'hFFFFEAAB) begin
            errors++;
            $display("FAIL trunc_neg: got q=%0d want -5461", $signed(q));
        end
        tick();
    endtask

    task automatic test_backpressure();
        int lat;
        out_ready = 1'b0;
        send(fx(9), fx(2), 8'h77);
        wait_valid(lat);
        a = fx(1); b = fx(1); in_tag = 8'h99; in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (out_valid !== 1'b1 || q !== 32'd73728 || out_tag !== 8'h77 || div_zero !== 1'b0 || overflow !== 1'b0 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold[%0d]: got valid=%b q=%0d tag=%h dz=%b ovf=%b rdy=%b want 1 73728 77 0 0 0",
                         i, out_valid, $signed(q), out_tag, div_zero, overflow, in_ready);
            end
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b want 1", in_ready); end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_handshake: out_valid=%b want 0", out_valid); end
    endtask

    task automatic test_reset_mid();
        int lat;
        logic seen;
        send(fx(50), fx(3), 8'h42);
        repeat (5) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_state: got rdy=%b valid=%b want 1 0", in_ready, out_valid);
        end
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (out_valid) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin errors++; $display("FAIL rst_mid_abandon: out_valid rose=%b want 0", seen); end
        send(fx(1), fx(4), 8'h43);
        wait_valid(lat);
        checks++;
        if (lat != 24 || q !== 32'd4096 || out_tag !== 8'h43) begin
            errors++;
            $display("FAIL rst_mid_next: got lat=%0d q=%0d tag=%h want 24 4096 43", lat, $signed(q), out_tag);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_div_zero();
        test_overflow();
        test_backpressure();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end
endmodule
